// File: rtl/lsu_mem_master_if.sv
// Request/response handshake and data-memory bus of the load/store initiator.
// The master modport is the initiator's view; slave is the execute stage plus memory side.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_data_input;
  logic [2:0]        load_format;
  logic [1:0]        store_format;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [63:0]       mem_data_output;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_data_output,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    output mem_addr, mem_data_input, load_format, store_format,
    output mem_write_en, mem_read_en
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output resp_ready, mem_data_output,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
    input  mem_addr, mem_data_input, load_format, store_format,
    input  mem_write_en, mem_read_en
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: validates one request, sequences SETUP/ACCESS on the data
// memory's level-sensitive enables, and returns extended load data with an error code.
module lsu_mem_master #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 4096
) (
  input logic                 clk,
  input logic                 reset,
  lsu_mem_master_if.master    bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  localparam logic [ADDR_W-1:0] LP_MEM_BYTES = ADDR_W'(MEM_BYTES);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic [4:0]        r_rd;
  logic [1:0]        r_err;
  logic              w_accept;
  logic              w_active;
  logic [1:0]        w_err;
  logic [ADDR_W-1:0] w_size;
  logic [63:0]       w_load_ext;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);

  // Bounds test is written as addr > MEM_BYTES - size so a huge address cannot wrap.
  always_comb begin
    w_size = ADDR_W'(1) << bus.req_funct3[1:0];
    w_err  = 2'b00;
    if ((bus.req_is_store && bus.req_funct3[2]) ||
        (!bus.req_is_store && bus.req_funct3 == 3'b111))
      w_err = 2'b11;
    else if ((bus.req_addr & (w_size - ADDR_W'(1))) != '0)
      w_err = 2'b01;
    else if ((w_size > LP_MEM_BYTES) || (bus.req_addr > LP_MEM_BYTES - w_size))
      w_err = 2'b10;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = (w_err != 2'b00) ? ST_RESP : ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   if (bus.resp_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Only the bytes of the access size are trusted; the rest of the word is discarded.
  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{56{bus.mem_data_output[7]}},  bus.mem_data_output[7:0]};
      3'b001:  w_load_ext = {{48{bus.mem_data_output[15]}}, bus.mem_data_output[15:0]};
      3'b010:  w_load_ext = {{32{bus.mem_data_output[31]}}, bus.mem_data_output[31:0]};
      3'b100:  w_load_ext = {56'd0, bus.mem_data_output[7:0]};
      3'b101:  w_load_ext = {48'd0, bus.mem_data_output[15:0]};
      3'b110:  w_load_ext = {32'd0, bus.mem_data_output[31:0]};
      default: w_load_ext = bus.mem_data_output;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= 64'd0;
      r_rdata    <= 64'd0;
      r_rd       <= 5'd0;
      r_err      <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_is_store <= bus.req_is_store;
        r_funct3   <= bus.req_funct3;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_rd       <= bus.req_rd;
        r_err      <= w_err;
        r_rdata    <= 64'd0;
      end
      if (r_state == ST_ACCESS && !r_is_store)
        r_rdata <= w_load_ext;
    end
  end

  // Memory-side fields are driven from SETUP through RESP for good transactions only.
  assign w_active = (r_state != ST_IDLE) && (r_err == 2'b00);

  assign bus.req_ready      = (r_state == ST_IDLE);
  assign bus.resp_valid     = (r_state == ST_RESP);
  assign bus.resp_rdata     = bus.resp_valid ? r_rdata : 64'd0;
  assign bus.resp_rd        = (bus.resp_valid && !r_is_store) ? r_rd : 5'd0;
  assign bus.resp_err       = bus.resp_valid ? r_err : 2'b00;
  assign bus.mem_addr       = w_active ? r_addr : '0;
  assign bus.mem_data_input = (w_active && r_is_store) ? r_wdata : 64'd0;
  assign bus.load_format    = (w_active && !r_is_store) ?
                              ((r_funct3[1:0] == 2'b11) ? 3'b101 : {1'b0, r_funct3[1:0]}) : 3'b000;
  assign bus.store_format   = (w_active && r_is_store) ? r_funct3[1:0] : 2'b00;
  assign bus.mem_write_en   = (r_state == ST_ACCESS) && r_is_store;
  assign bus.mem_read_en    = (r_state == ST_ACCESS) && !r_is_store;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-array memory model, directed scenarios, then random
// requests checked against a reference model of errors, extension and memory contents.
module tb_lsu_mem_master;
  localparam int ADDR_W    = 64;
  localparam int MEM_BYTES = 4096;

  logic clk = 1'b0;
  logic reset;
  logic fill_en;
  logic [63:0] garbage;
  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_master #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic int fmt_bytes(input logic [2:0] lf);
    case (lf)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 8;
    endcase
  endfunction

  // Memory: writes land at the edge closing the enabled cycle; reads are combinational,
  // with bytes beyond the access size filled with junk to exercise masking.
  always @(posedge clk) begin
    garbage <= {$urandom, $urandom};
    if (fill_en) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= fill_byte(i);
    end else if (bus.mem_write_en) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << bus.store_format) && (bus.mem_addr + 64'(i)) < 64'(MEM_BYTES))
          mem[12'(bus.mem_addr + 64'(i))] <= bus.mem_data_input[8*i +: 8];
    end
  end

  always_comb begin
    bus.mem_data_output = garbage;
    for (int i = 0; i < 8; i++)
      if (i < fmt_bytes(bus.load_format) && (bus.mem_addr + 64'(i)) < 64'(MEM_BYTES))
        bus.mem_data_output[8*i +: 8] = mem[12'(bus.mem_addr + 64'(i))];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_err(input logic st, input logic [2:0] f3, input logic [63:0] addr);
    longint unsigned n = 64'(1) << f3[1:0];
    if (st ? (f3 > 3'd3) : (f3 == 3'd7)) return 2'b11;
    if (addr % n != 0) return 2'b01;
    if (addr >= 64'(MEM_BYTES) || addr + n > 64'(MEM_BYTES)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
    logic [63:0] v = 64'd0;
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr[11:0]) + i];
    case (f3)
      3'd0:    return 64'(signed'(v[7:0]));
      3'd1:    return 64'(signed'(v[15:0]));
      3'd2:    return 64'(signed'(v[31:0]));
      default: return v;
    endcase
  endfunction

  function automatic logic [2:0] ref_lfmt(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 3'b000;
      3'd1, 3'd5: return 3'b001;
      3'd2, 3'd6: return 3'b010;
      default:    return 3'b101;
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd, input int hold);
    logic [1:0]  e_err  = ref_err(st, f3, addr);
    logic [63:0] e_data = (st || e_err != 2'b00) ? 64'd0 : ref_load(f3, addr);
    logic [4:0]  e_rd   = st ? 5'd0 : rd;
    int k = 1, lat = 0, wr_cnt = 0, rd_cnt = 0;
    bit got = 0;
    check_eq("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!got && k <= 8) begin
      if (bus.mem_write_en || bus.mem_read_en) begin
        check_eq("en_exclusive", 64'(bus.mem_write_en & bus.mem_read_en), 64'd0);
        check_eq("en_cycle", 64'(k), 64'd2);
        check_eq("mem_addr_access", bus.mem_addr, addr);
        if (st) begin
          check_eq("store_format", 64'(bus.store_format), 64'(f3[1:0]));
          check_eq("mem_data_input", bus.mem_data_input, wd);
        end else begin
          check_eq("load_format", 64'(bus.load_format), 64'(ref_lfmt(f3)));
        end
      end
      wr_cnt += int'(bus.mem_write_en);
      rd_cnt += int'(bus.mem_read_en);
      if (bus.resp_valid) begin
        got = 1;
        lat = k;
      end else begin
        check_eq("req_ready_busy", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        k++;
      end
    end
    check_eq("resp_timeout", 64'(got), 64'd1);
    check_eq("latency", 64'(lat), (got && e_err == 2'b00) ? 64'd3 : (got ? 64'd1 : 64'd0));
    check_eq("write_pulses", 64'(wr_cnt), 64'(st && e_err == 2'b00));
    check_eq("read_pulses", 64'(rd_cnt), 64'(!st && e_err == 2'b00));
    for (int h = 0; got && h <= hold; h++) begin
      check_eq("resp_valid_hold", 64'(bus.resp_valid), 64'd1);
      check_eq("resp_err", 64'(bus.resp_err), 64'(e_err));
      check_eq("resp_rdata", bus.resp_rdata, e_data);
      check_eq("resp_rd", 64'(bus.resp_rd), 64'(e_rd));
      check_eq("req_ready_resp", 64'(bus.req_ready), 64'd0);
      check_eq("en_resp", 64'(bus.mem_write_en | bus.mem_read_en), 64'd0);
      if (e_err == 2'b00) check_eq("mem_addr_resp", bus.mem_addr, addr);
      if (h == hold) bus.resp_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b0;
    check_eq("resp_valid_after", 64'(bus.resp_valid), 64'd0);
    check_eq("req_ready_after", 64'(bus.req_ready), 64'd1);
    check_eq("mem_addr_idle", bus.mem_addr, 64'd0);
    if (st && e_err == 2'b00)
      for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[int'(addr[11:0]) + i] = wd[8*i +: 8];
    $display("txn %s f3=%0d addr=0x%0h rd=%0d hold=%0d exp_err=%0d exp_rdata=0x%0h lat=%0d",
             st ? "ST" : "LD", f3, addr, rd, hold, e_err, e_data, lat);
  endtask

  // Store aborted by reset while its write enable is high; memory must be untouched.
  task automatic reset_in_access();
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'd3;
    bus.req_addr     = 64'h40;
    bus.req_wdata    = 64'hA5A5_5A5A_0F0F_F0F0;
    bus.req_rd       = 5'd0;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_we_before", 64'(bus.mem_write_en), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_we_after", 64'(bus.mem_write_en), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 64'd0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    $display("txn ST f3=3 addr=0x40 aborted by reset in ACCESS");
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] addr;
    int n, r;
    reset = 1'b1;
    fill_en = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_rd = 5'd0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = fill_byte(i);
    #2;
    check_eq("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("reset_enables", 64'({bus.mem_write_en, bus.mem_read_en}), 64'd0);
    check_eq("reset_mem_addr", bus.mem_addr, 64'd0);
    check_eq("reset_resp_rdata", bus.resp_rdata, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    fill_en = 1'b0;
    reset = 1'b0;

    do_txn(1'b1, 3'd3, 64'h10, 64'h1122334455667788, 5'd0, 0);
    do_txn(1'b0, 3'd3, 64'h10, 64'd0, 5'd5, 0);
    do_txn(1'b1, 3'd0, 64'h20, 64'hDEAD_BEEF_CAFE_BA80, 5'd0, 0);
    do_txn(1'b0, 3'd0, 64'h20, 64'd0, 5'd1, 1);
    do_txn(1'b0, 3'd4, 64'h20, 64'd0, 5'd2, 0);
    do_txn(1'b0, 3'd2, 64'h22, 64'd0, 5'd3, 0);
    do_txn(1'b0, 3'd3, 64'd4092, 64'd0, 5'd4, 0);
    do_txn(1'b1, 3'd4, 64'h50, 64'h1234, 5'd0, 0);
    do_txn(1'b0, 3'd7, 64'h50, 64'd0, 5'd6, 0);
    do_txn(1'b1, 3'd1, 64'h30, 64'h0000_0000_0000_8001, 5'd0, 0);
    do_txn(1'b0, 3'd1, 64'h30, 64'd0, 5'd7, 3);
    do_txn(1'b0, 3'd3, 64'd4088, 64'd0, 5'd8, 0);
    do_txn(1'b1, 3'd0, 64'd4095, 64'h77, 5'd0, 0);
    do_txn(1'b0, 3'd4, 64'd4095, 64'd0, 5'd9, 0);
    do_txn(1'b0, 3'd6, 64'd4096, 64'd0, 5'd10, 0);
    do_txn(1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 5'd11, 0);
    reset_in_access();
    do_txn(1'b0, 3'd3, 64'h40, 64'd0, 5'd12, 0);

    for (int t = 0; t < 300; t++) begin
      f3 = 3'($urandom);
      n = 1 << f3[1:0];
      r = int'($urandom_range(0, 9));
      if (r < 6)       addr = 64'(($urandom % 256) & ~(n - 1));
      else if (r == 6) addr = 64'($urandom % 256);
      else if (r == 7) addr = 64'(MEM_BYTES - 8 + int'($urandom % 8));
      else if (r == 8) addr = 64'(MEM_BYTES - n * int'($urandom % 3));
      else             addr = {$urandom, $urandom};
      do_txn(1'($urandom), f3, addr, {$urandom, $urandom}, 5'($urandom), int'($urandom % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
